axi_wr_back_end: RTL and testbench

Transmitting end of the AXI write channel set: accepts one packed write packet (`axi_addr_data_pkt`: id, length, addr, d0..d15) from the interconnect core and drives it onto an AXI slave as one AW transfer, a W burst of `length+1` 32-bit beats and one B response collection. It sits at the master-side edge of the interconnect, opposite the AXI write front end, and reports completion status (including a response watchdog) back to the core.

---
 rtl/gen_definitions.sv | 43 ++++
 rtl/axi_wr_back_end_if.sv | 31 +++
 rtl/axi_wr_back_end.sv | 168 ++++++++++++++++
 tb/tb_axi_wr_back_end.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gen_definitions.sv
// Shared types for the AXI write back end: packed write packet, bresp codes,
// FSM state encoding and the bundle of registered outputs.
package gen_definitions;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [3:0]  id;
    logic [3:0]  length;
    logic [31:0] addr;
    logic [31:0] d0,  d1,  d2,  d3,  d4,  d5,  d6,  d7;
    logic [31:0] d8,  d9,  d10, d11, d12, d13, d14, d15;
  } axi_addr_data_pkt;

  // Every output of the block is a flop; keeping them in one struct lets
  // reset clear them in a single assignment.
  typedef struct packed {
    logic        awvalid;
    logic [3:0]  awid;
    logic [3:0]  awlen;
    logic [31:0] awaddr;
    logic        wvalid;
    logic [31:0] wdata;
    logic        wlast;
    logic        bready;
    logic        hold;
    logic        done;
    logic [3:0]  done_id;
    logic        err;
    logic        timeout;
  } wr_out_t;

endpackage

// File: rtl/axi_wr_back_end_if.sv
// AXI write address / data / response channel bundles.
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; once valid is raised the payload stays stable until that edge.

interface axi_wr_addr_intf;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [3:0]  awlen;
  logic [31:0] awaddr;
  modport MASTER (output awvalid, awid, awlen, awaddr, input awready);
  modport SLAVE  (input awvalid, awid, awlen, awaddr, output awready);
endinterface

interface axi_wr_data_intf;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic        wlast;
  modport MASTER (output wvalid, wdata, wlast, input wready);
  modport SLAVE  (input wvalid, wdata, wlast, output wready);
endinterface

interface axi_wr_resp_intf;
  logic       bvalid;
  logic       bready;
  logic [3:0] bid;
  logic [1:0] bresp;
  modport MASTER (output bvalid, bid, bresp, input bready);
  modport SLAVE  (input bvalid, bid, bresp, output bready);
endinterface

// File: rtl/axi_wr_back_end.sv
// Issues one latched write packet as AW, a W burst of length+1 beats and a
// B collection with a response watchdog; reports completion to the core.
module axi_wr_back_end
  import gen_definitions::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_wr_addr_intf.MASTER         addr_intf,
  axi_wr_data_intf.MASTER         data_intf,
  axi_wr_resp_intf.SLAVE          resp_intf,
  input  logic                    axi_wr_pkt_vld,
  input  axi_addr_data_pkt        axi_wr_pkt,
  output logic                    hold_out,
  output logic                    wr_done,
  output logic [3:0]              wr_done_id,
  output logic                    wr_err,
  output logic                    wr_timeout,
  output wr_state_e               state_dbg
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  wr_state_e        state_q, state_n;
  axi_addr_data_pkt pkt_q, pkt_n;
  logic [3:0]       beat_q, beat_n;
  logic [7:0]       wd_q, wd_n;
  wr_out_t          out_q, out_n;
  logic [3:0]       beat_sel;
  logic [31:0]      beat_data;

  // Index of the beat loaded into wdata at the coming edge: d0 when leaving
  // ADDR, the following beat while in DATA.
  assign beat_sel = (state_q == DATA) ? beat_q + 4'd1 : 4'd0;

  always_comb begin
    beat_data = '0;
    case (beat_sel)
      4'd0:  beat_data = pkt_q.d0;
      4'd1:  beat_data = pkt_q.d1;
      4'd2:  beat_data = pkt_q.d2;
      4'd3:  beat_data = pkt_q.d3;
      4'd4:  beat_data = pkt_q.d4;
      4'd5:  beat_data = pkt_q.d5;
      4'd6:  beat_data = pkt_q.d6;
      4'd7:  beat_data = pkt_q.d7;
      4'd8:  beat_data = pkt_q.d8;
      4'd9:  beat_data = pkt_q.d9;
      4'd10: beat_data = pkt_q.d10;
      4'd11: beat_data = pkt_q.d11;
      4'd12: beat_data = pkt_q.d12;
      4'd13: beat_data = pkt_q.d13;
      4'd14: beat_data = pkt_q.d14;
      4'd15: beat_data = pkt_q.d15;
      default: beat_data = '0;
    endcase
  end

  always_comb begin
    state_n       = state_q;
    pkt_n         = pkt_q;
    beat_n        = beat_q;
    wd_n          = wd_q;
    out_n         = out_q;
    out_n.done    = 1'b0;
    out_n.done_id = 4'd0;
    out_n.err     = 1'b0;
    out_n.timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (axi_wr_pkt_vld) begin
          pkt_n         = axi_wr_pkt;
          beat_n        = 4'd0;
          wd_n          = 8'd0;
          out_n.awvalid = 1'b1;
          out_n.awid    = axi_wr_pkt.id;
          out_n.awlen   = axi_wr_pkt.length;
          out_n.awaddr  = axi_wr_pkt.addr;
          out_n.hold    = 1'b1;
          state_n       = ADDR;
        end
      end
      ADDR: begin
        if (addr_intf.awready) begin
          out_n.awvalid = 1'b0;
          out_n.awid    = 4'd0;
          out_n.awlen   = 4'd0;
          out_n.awaddr  = 32'd0;
          out_n.wvalid  = 1'b1;
          out_n.wdata   = beat_data;
          out_n.wlast   = (pkt_q.length == 4'd0);
          state_n       = DATA;
        end
      end
      DATA: begin
        if (data_intf.wready) begin
          if (out_q.wlast) begin
            out_n.wvalid = 1'b0;
            out_n.wdata  = 32'd0;
            out_n.wlast  = 1'b0;
            out_n.bready = 1'b1;
            wd_n         = 8'd0;
            state_n      = RESP;
          end else begin
            beat_n      = beat_sel;
            out_n.wdata = beat_data;
            out_n.wlast = (beat_sel == pkt_q.length);
          end
        end
      end
      RESP: begin
        // A response arriving in the final watchdog cycle still wins.
        if (resp_intf.bvalid) begin
          out_n.bready  = 1'b0;
          out_n.hold    = 1'b0;
          out_n.done    = 1'b1;
          out_n.done_id = pkt_q.id;
          out_n.err     = (resp_intf.bresp != OKAY) | (resp_intf.bid != pkt_q.id);
          state_n       = IDLE;
        end else if (wd_q == TO_LAST) begin
          out_n.bready  = 1'b0;
          out_n.hold    = 1'b0;
          out_n.done    = 1'b1;
          out_n.done_id = pkt_q.id;
          out_n.err     = 1'b1;
          out_n.timeout = 1'b1;
          state_n       = IDLE;
        end else begin
          wd_n = wd_q + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      beat_q  <= 4'd0;
      wd_q    <= 8'd0;
      out_q   <= '0;
    end else begin
      state_q <= state_n;
      pkt_q   <= pkt_n;
      beat_q  <= beat_n;
      wd_q    <= wd_n;
      out_q   <= out_n;
    end
  end

  assign addr_intf.awvalid = out_q.awvalid;
  assign addr_intf.awid    = out_q.awid;
  assign addr_intf.awlen   = out_q.awlen;
  assign addr_intf.awaddr  = out_q.awaddr;
  assign data_intf.wvalid  = out_q.wvalid;
  assign data_intf.wdata   = out_q.wdata;
  assign data_intf.wlast   = out_q.wlast;
  assign resp_intf.bready  = out_q.bready;
  assign hold_out          = out_q.hold;
  assign wr_done           = out_q.done;
  assign wr_done_id        = out_q.done_id;
  assign wr_err            = out_q.err;
  assign wr_timeout        = out_q.timeout;
  assign state_dbg         = state_q;

endmodule

// File: tb/tb_axi_wr_back_end.sv
// Scoreboard bench for axi_wr_back_end: directed scenarios plus random packets
// against a reactive AXI slave model.
module tb_axi_wr_back_end;
  import gen_definitions::*;

  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  axi_wr_addr_intf aw_if ();
  axi_wr_data_intf w_if ();
  axi_wr_resp_intf b_if ();

  logic             pkt_vld;
  axi_addr_data_pkt pkt;
  logic             hold_out, wr_done, wr_err, wr_timeout;
  logic [3:0]       wr_done_id;
  wr_state_e        state_dbg;

  axi_wr_back_end #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .addr_intf(aw_if), .data_intf(w_if), .resp_intf(b_if),
    .axi_wr_pkt_vld(pkt_vld), .axi_wr_pkt(pkt),
    .hold_out(hold_out), .wr_done(wr_done), .wr_done_id(wr_done_id),
    .wr_err(wr_err), .wr_timeout(wr_timeout), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [39:0] aw_exp_q[$];    // {id, len, addr}
  logic [32:0] w_exp_q[$];     // {last, data}
  logic [30:0] done_exp_q[$];  // {chk_lat, lat[7:0], acc_cyc[15:0], id, err, timeout}

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush_expect();
    aw_exp_q.delete();
    w_exp_q.delete();
    done_exp_q.delete();
  endtask

  // ---------------- slave model knobs ----------------
  int          aw_wait   = 0;
  int          w_mode    = 0;   // 0 always ready, 1 toggling, 2 random
  int          b_delay   = 0;
  bit          b_never   = 1'b0;
  logic [1:0]  b_resp    = 2'b00;
  logic [3:0]  bid_flip  = 4'd0;
  int          late_req  = 0;
  int          late_done = 0;
  logic [3:0]  aw_id_seen = 4'd0;
  int          w_hs_cnt  = 0;
  int          resp_cnt  = 0;

  initial begin
    int aw_cnt;
    int b_cnt;
    aw_cnt = 0;
    b_cnt  = 0;
    aw_if.awready = 1'b0;
    w_if.wready   = 1'b0;
    b_if.bvalid   = 1'b0;
    b_if.bid      = 4'd0;
    b_if.bresp    = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !aw_if.awvalid) begin
        aw_cnt = 0;
        aw_if.awready = 1'b0;
      end else if (aw_cnt >= aw_wait) begin
        aw_if.awready = 1'b1;
      end else begin
        aw_if.awready = 1'b0;
        aw_cnt++;
      end
      case (w_mode)
        0:       w_if.wready = 1'b1;
        1:       w_if.wready = ~w_if.wready;
        default: w_if.wready = 1'($urandom_range(0, 1));
      endcase
      b_if.bvalid = 1'b0;
      if (late_req != late_done) begin
        late_done++;
        b_if.bvalid = 1'b1;
        b_if.bid    = aw_id_seen;
        b_if.bresp  = 2'b00;
      end else if (b_if.bready && !b_never && !rst) begin
        if (b_cnt >= b_delay) begin
          b_if.bvalid = 1'b1;
          b_if.bid    = aw_id_seen ^ bid_flip;
          b_if.bresp  = b_resp;
          b_cnt = 0;
        end else begin
          b_cnt++;
        end
      end else begin
        b_cnt = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [30:0] e;
    if (rst) begin
      resp_cnt = 0;
    end else begin
      if (b_if.bready) resp_cnt++;
      if (aw_if.awvalid) begin
        if (aw_exp_q.size() == 0) check("aw_unexpected", 1, 0);
        else begin
          check("aw_payload", {aw_if.awid, aw_if.awlen, aw_if.awaddr}, aw_exp_q[0]);
          if (aw_if.awready) begin
            aw_id_seen = aw_if.awid;
            void'(aw_exp_q.pop_front());
          end
        end
      end else begin
        check("aw_idle_zero", {aw_if.awid, aw_if.awlen, aw_if.awaddr}, 0);
      end
      if (w_if.wvalid) begin
        check("w_before_aw", aw_exp_q.size(), 0);
        if (w_exp_q.size() == 0) check("w_unexpected", 1, 0);
        else begin
          check("w_beat", {w_if.wlast, w_if.wdata}, w_exp_q[0]);
          if (w_if.wready) begin
            void'(w_exp_q.pop_front());
            w_hs_cnt++;
          end
        end
      end else begin
        check("w_idle_zero", {w_if.wlast, w_if.wdata}, 0);
      end
      if (wr_done) begin
        if (done_exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          e = done_exp_q.pop_front();
          check("done_id", wr_done_id, e[5:2]);
          check("done_err", wr_err, e[1]);
          check("done_timeout", wr_timeout, e[0]);
          if (e[30]) check("latency", 16'(cyc[15:0] - e[21:6]), e[29:22]);
          if (e[0]) check("timeout_cycles", resp_cnt, TIMEOUT);
        end
        resp_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  logic [31:0] tx_dat[16];

  function automatic axi_addr_data_pkt make_pkt(input logic [3:0] id, input logic [3:0] len,
                                                input logic [31:0] addr);
    axi_addr_data_pkt p;
    p = {id, len, addr, tx_dat[0], tx_dat[1], tx_dat[2], tx_dat[3], tx_dat[4], tx_dat[5],
         tx_dat[6], tx_dat[7], tx_dat[8], tx_dat[9], tx_dat[10], tx_dat[11], tx_dat[12],
         tx_dat[13], tx_dat[14], tx_dat[15]};
    return p;
  endfunction

  task automatic send_pkt(input logic [3:0] id, input logic [3:0] len, input logic [31:0] addr,
                          input bit chk_lat);
    int budget;
    logic exp_err, exp_to;
    @(negedge clk);
    pkt_vld = 1'b1;
    pkt     = make_pkt(id, len, addr);
    budget  = 0;
    while (hold_out && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (hold_out) begin
      check("accept_wait_timeout", 1, 0);
      pkt_vld = 1'b0;
      return;
    end
    // Reference: AW carries the header, then len+1 beats d0.., last on beat len.
    exp_to  = b_never;
    exp_err = b_never | (b_resp != 2'b00) | (bid_flip != 4'd0);
    aw_exp_q.push_back({id, len, addr});
    for (int i = 0; i <= int'(len); i++) w_exp_q.push_back({(i == int'(len)), tx_dat[i]});
    done_exp_q.push_back({chk_lat, 8'(int'(len) + 4), cyc[15:0], id, exp_err, exp_to});
    @(posedge clk);
    #1;
    pkt_vld = 1'b0;
  endtask

  task automatic wait_done();
    int budget;
    budget = 0;
    while (done_exp_q.size() != 0 && budget < 1000) begin
      @(negedge clk);
      budget++;
    end
    if (done_exp_q.size() != 0) begin
      check("done_wait_timeout", 1, 0);
      flush_expect();
    end
  endtask

  task automatic rand_data();
    for (int i = 0; i < 16; i++) tx_dat[i] = $urandom;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awvalid"}, aw_if.awvalid, 0);
    check({tag, "_wvalid"}, {w_if.wvalid, w_if.wlast, w_if.wdata}, 0);
    check({tag, "_awpayload"}, {aw_if.awid, aw_if.awlen, aw_if.awaddr}, 0);
    check({tag, "_bready"}, b_if.bready, 0);
    check({tag, "_hold"}, hold_out, 0);
    check({tag, "_done"}, {wr_done, wr_done_id, wr_err, wr_timeout}, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    pkt_vld = 1'b0;
    pkt     = '0;
    for (int i = 0; i < 16; i++) tx_dat[i] = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Single beat, zero-wait slave, 4 cycles accept to done.
    tx_dat[0] = 32'hA5A5_A5A5;
    send_pkt(4'd3, 4'd0, 32'h0000_1000, 1'b1);
    wait_done();

    // 16 beats with a stalling W channel.
    for (int i = 0; i < 16; i++) tx_dat[i] = i;
    w_mode = 1;
    send_pkt(4'd7, 4'd15, 32'h0000_2000, 1'b0);
    wait_done();
    w_mode = 0;

    // Full-length zero-wait burst: 19 cycles accept to done.
    rand_data();
    send_pkt(4'd9, 4'd15, 32'h0000_2400, 1'b1);
    wait_done();

    // AW stall with a second packet offered behind it.
    aw_wait = 5;
    rand_data();
    send_pkt(4'd1, 4'd2, 32'h0000_3000, 1'b0);
    @(negedge clk);
    pkt_vld = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall_hold", hold_out, 1);
      check("stall_awvalid", aw_if.awvalid, 1);
      @(negedge clk);
    end
    aw_wait = 0;
    rand_data();
    send_pkt(4'd2, 4'd1, 32'h0000_3100, 1'b0);
    wait_done();

    // Error responses: SLVERR, then bid mismatch (5 vs 4).
    b_resp = SLVERR;
    send_pkt(4'd6, 4'd3, 32'h0000_4000, 1'b0);
    wait_done();
    b_resp   = 2'b00;
    bid_flip = 4'd4 ^ 4'd5;
    send_pkt(4'd4, 4'd0, 32'h0000_4100, 1'b0);
    wait_done();
    bid_flip = 4'd0;

    // Watchdog, then a late bvalid that must be ignored.
    b_never = 1'b1;
    send_pkt(4'd8, 4'd1, 32'h0000_5000, 1'b0);
    wait_done();
    late_req++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("late_ignored", {b_if.bready, wr_done, hold_out}, 0);
    end
    b_never = 1'b0;

    // Reset in the middle of a 16-beat burst.
    begin
      int base, budget;
      rand_data();
      base = w_hs_cnt;
      send_pkt(4'd10, 4'd15, 32'h0000_6000, 1'b0);
      budget = 0;
      while (w_hs_cnt < base + 6 && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      check("reached_beat6", (w_hs_cnt >= base + 6), 1);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midrst");
      flush_expect();
      rst = 1'b0;
      rand_data();
      send_pkt(4'd11, 4'd3, 32'h0000_7000, 1'b1);
      wait_done();
    end

    // Randomized traffic.
    for (int n = 0; n < 25; n++) begin
      aw_wait  = $urandom_range(0, 3);
      w_mode   = $urandom_range(0, 2);
      b_delay  = $urandom_range(0, 4);
      r        = $urandom_range(0, 9);
      b_never  = (r == 0);
      b_resp   = (r >= 8) ? 2'($urandom_range(1, 3)) : 2'b00;
      bid_flip = (r == 7) ? 4'($urandom_range(1, 15)) : 4'd0;
      rand_data();
      send_pkt(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, 1'b0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("queues_drained", {aw_exp_q.size() != 0, w_exp_q.size() != 0, done_exp_q.size() != 0}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
